// File: rtl/ffmon_pkg.sv
// Shared state encoding and default sizes for the flip-flop fault monitor.
package ffmon_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_SETTLE  = 3'd3,
        S_MONITOR = 3'd4,
        S_REPORT  = 3'd5
    } state_e;

    localparam int SETTLE_CYCLES = 2;

    localparam int N_DEF       = 8;
    localparam int TIMER_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/ffmon_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ffmon_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ff_fault_monitor.sv
// Clears, loads and watches the LFI flip-flop target; reports each bit flip as a record.
// Define FFMON_AUTO_RELOAD_EN to re-load and re-arm automatically after each accepted record.
module ff_fault_monitor
    import ffmon_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMER_W = TIMER_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [N-1:0]       pattern,
    output logic               dut_en,
    output logic               dut_reset,
    output logic [N-1:0]       dut_d,
    input  logic [N-1:0]       dut_q,
    output logic               armed,
    output logic               load_err,
    output logic               fault_valid,
    input  logic               fault_ready,
    output logic [N-1:0]       fault_mask,
    output logic [N-1:0]       fault_q,
    output logic [TIMER_W-1:0] fault_time,
    output logic [CNT_W-1:0]   fault_count,
    output logic [2:0]         dbg_state
);

    state_e             state_q, state_d;
    logic [N-1:0]       expected_q, expected_d;
    logic [N-1:0]       q_r;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         settle_q, settle_d;
    logic               load_err_q, load_err_d;
    logic               fv_q, fv_d;
    logic [N-1:0]       mask_q, mask_d;
    logic [N-1:0]       fq_q, fq_d;
    logic [TIMER_W-1:0] ftime_q, ftime_d;
    logic               stop_pend_q, stop_pend_d;
    logic               cnt_clr;
    logic               cnt_inc;

    // fault_valid/ready handshake: a record is held stable while fault_valid is high and is
    // consumed on the rising edge where fault_ready is sampled high.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        timer_d     = timer_q;
        settle_d    = settle_q;
        load_err_d  = load_err_q;
        fv_d        = fv_q;
        mask_d      = mask_q;
        fq_d        = fq_q;
        ftime_d     = ftime_q;
        stop_pend_d = stop_pend_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        dut_en      = 1'b0;
        dut_reset   = 1'b0;
        dut_d       = '0;
        armed       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    expected_d = pattern;
                    load_err_d = 1'b0;
                    cnt_clr    = 1'b1;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dut_en    = 1'b1;
                dut_reset = 1'b1;
                state_d   = stop ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                dut_en   = 1'b1;
                dut_d    = expected_q;
                settle_d = '0;
                state_d  = stop ? S_IDLE : S_SETTLE;
            end
            S_SETTLE: begin
                dut_d = expected_q;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
                    if (q_r != expected_q) begin
                        load_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = S_MONITOR;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_MONITOR: begin
                armed   = 1'b1;
                timer_d = timer_q + 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (q_r != expected_q) begin
                    mask_d      = q_r ^ expected_q;
                    fq_d        = q_r;
                    ftime_d     = timer_q;
                    fv_d        = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                // A stop seen while the record is pending only takes effect after acceptance.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (fault_ready) begin
                    fv_d    = 1'b0;
                    cnt_inc = 1'b1;
`ifdef FFMON_AUTO_RELOAD_EN
                    state_d = (stop || stop_pend_q) ? S_IDLE : S_LOAD;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            expected_q  <= '0;
            q_r         <= '0;
            timer_q     <= '0;
            settle_q    <= '0;
            load_err_q  <= 1'b0;
            fv_q        <= 1'b0;
            mask_q      <= '0;
            fq_q        <= '0;
            ftime_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            q_r         <= dut_q;
            timer_q     <= timer_d;
            settle_q    <= settle_d;
            load_err_q  <= load_err_d;
            fv_q        <= fv_d;
            mask_q      <= mask_d;
            fq_q        <= fq_d;
            ftime_q     <= ftime_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    ffmon_sat_counter #(.W(CNT_W)) u_fault_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (fault_count)
    );

    assign load_err    = load_err_q;
    assign fault_valid = fv_q;
    assign fault_mask  = mask_q;
    assign fault_q     = fq_q;
    assign fault_time  = ftime_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ff_fault_monitor.sv
// Bench for ff_fault_monitor: directed scenarios plus random traffic against a behavioural model.
module tb_ff_fault_monitor;

    localparam int N       = 8;
    localparam int TW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FFMON_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          fault_ready = 1'b0;
    logic [N-1:0]  pattern = '0;
    logic          dut_en, dut_reset, armed, load_err, fault_valid;
    logic [N-1:0]  dut_d, dut_q, fault_mask, fault_q;
    logic [TW-1:0] fault_time;
    logic [CW-1:0] fault_count;
    logic [2:0]    dbg_state;

    ff_fault_monitor #(.N(N), .TIMER_W(TW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .pattern     (pattern),
        .dut_en      (dut_en),
        .dut_reset   (dut_reset),
        .dut_d       (dut_d),
        .dut_q       (dut_q),
        .armed       (armed),
        .load_err    (load_err),
        .fault_valid (fault_valid),
        .fault_ready (fault_ready),
        .fault_mask  (fault_mask),
        .fault_q     (fault_q),
        .fault_time  (fault_time),
        .fault_count (fault_count),
        .dbg_state   (dbg_state)
    );

    // target register array with stuck-at-0 bits and laser flips
    logic [N-1:0] tgt;
    logic [N-1:0] flip_mask = '0;
    logic [N-1:0] stuck_mask = '0;
    assign dut_q = (tgt & ~stuck_mask) ^ flip_mask;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)    tgt <= '0;
        else if (dut_en) tgt <= dut_reset ? '0 : dut_d;
    end

    // behavioural model: mode 0 idle, 1 load sequence, 2 monitoring, 3 reporting
    int            m_mode, m_seq, m_cnt;
    logic [N-1:0]  m_exp, m_qr, m_mask, m_fq;
    logic [TW-1:0] m_timer, m_ftime;
    logic          m_fv, m_lerr, m_spend;

    task automatic model_reset();
        m_mode = 0; m_seq = 0; m_cnt = 0;
        m_exp = '0; m_qr = '0; m_mask = '0; m_fq = '0;
        m_timer = '0; m_ftime = '0;
        m_fv = 1'b0; m_lerr = 1'b0; m_spend = 1'b0;
    endtask

    task automatic model_step();
        case (m_mode)
            0: if (start) begin
                m_exp = pattern; m_lerr = 1'b0; m_cnt = 0; m_mode = 1; m_seq = 0;
            end
            1: if (stop) m_mode = 0;
               else if (m_seq < 3) m_seq++;
               else if (m_qr != m_exp) begin m_lerr = 1'b1; m_mode = 0; end
               else begin m_timer = '0; m_mode = 2; end
            2: begin
                if (stop) m_mode = 0;
                else if (m_qr != m_exp) begin
                    m_mask = m_qr ^ m_exp; m_fq = m_qr; m_ftime = m_timer;
                    m_fv = 1'b1; m_spend = 1'b0; m_mode = 3;
                end
                m_timer = m_timer + 1;
            end
            3: begin
                if (fault_ready) begin
                    m_fv = 1'b0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (AUTO && !stop && !m_spend) begin m_mode = 1; m_seq = 1; end
                    else m_mode = 0;
                end
                if (stop) m_spend = 1'b1;
            end
            default: m_mode = 0;
        endcase
        m_qr = dut_q;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // scoreboard
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("dut_en",      64'(dut_en),      64'(m_mode == 1 && m_seq <= 1));
        chk("dut_reset",   64'(dut_reset),   64'(m_mode == 1 && m_seq == 0));
        chk("dut_d",       64'(dut_d),       64'((m_mode == 1 && m_seq >= 1) ? m_exp : '0));
        chk("armed",       64'(armed),       64'(m_mode == 2));
        chk("load_err",    64'(load_err),    64'(m_lerr));
        chk("fault_valid", 64'(fault_valid), 64'(m_fv));
        chk("fault_mask",  64'(fault_mask),  64'(m_mask));
        chk("fault_q",     64'(fault_q),     64'(m_fq));
        chk("fault_time",  64'(fault_time),  64'(m_ftime));
        chk("fault_count", 64'(fault_count), 64'(m_cnt));
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] p);
        pattern = p; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic go_idle();
        flip_mask = '0; stuck_mask = '0;
        stop = 1'b1; fault_ready = 1'b1;
        tick(2);
        stop = 1'b0; fault_ready = 1'b0;
    endtask

    task automatic wait_armed(input int max_cycles);
        int i = 0;
        while (armed !== 1'b1 && i < max_cycles) begin tick(1); i++; end
        chk("wait_armed_timeout", 64'(armed), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int exp_seq[5] = '{1, 2, 3, 3, 3};

    initial begin
        // reset and idle
        tick(3);
        @(negedge clk);
        chk("rst_dut_en", 64'(dut_en), 0);
        chk("rst_fault_valid", 64'(fault_valid), 0);
        chk("rst_fault_time", 64'(fault_time), 0);
        reset_n = 1'b1;
        tick(100);
        @(negedge clk);
        chk("idle_dut_en", 64'(dut_en), 0);
        chk("idle_armed", 64'(armed), 0);

        // clean run with A5
        pulse_start(8'hA5);
        @(negedge clk);
        chk("clear_en", 64'(dut_en), 1);
        chk("clear_rst", 64'(dut_reset), 1);
        tick(1); @(negedge clk);
        chk("load_en", 64'(dut_en), 1);
        chk("load_rst", 64'(dut_reset), 0);
        chk("load_d", 64'(dut_d), 64'hA5);
        tick(1); @(negedge clk);
        chk("settle1_armed", 64'(armed), 0);
        chk("settle1_en", 64'(dut_en), 0);
        tick(1); @(negedge clk);
        chk("settle2_armed", 64'(armed), 0);
        tick(1); @(negedge clk);
        chk("mon_armed", 64'(armed), 1);
        tick(1000); @(negedge clk);
        chk("clean_no_fault", 64'(fault_valid), 0);
        chk("clean_still_armed", 64'(armed), 1);

        // injected flip at timer 37
        go_idle();
        pulse_start(8'hA5);
        tick(4);
        tick(36);
        flip_mask = 8'h01;
        tick(1); @(negedge clk);
        chk("flip_lat1_valid", 64'(fault_valid), 0);
        tick(1); @(negedge clk);
        chk("flip_valid", 64'(fault_valid), 1);
        chk("flip_mask", 64'(fault_mask), 64'h01);
        chk("flip_q", 64'(fault_q), 64'hA4);
        chk("flip_time", 64'(fault_time), 64'd37);
        flip_mask = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1); @(negedge clk);
            chk("hold_valid", 64'(fault_valid), 1);
            chk("hold_mask", 64'(fault_mask), 64'h01);
            chk("hold_time", 64'(fault_time), 64'd37);
        end
        fault_ready = 1'b1;
        tick(1);
        fault_ready = 1'b0;
        @(negedge clk);
        chk("accept_valid", 64'(fault_valid), 0);
        chk("accept_count", 64'(fault_count), 1);
`ifdef FFMON_AUTO_RELOAD_EN
        chk("reload_en", 64'(dut_en), 1);
        chk("reload_d", 64'(dut_d), 64'hA5);
        tick(3); @(negedge clk);
        chk("reload_armed", 64'(armed), 1);
`else
        chk("noreload_en", 64'(dut_en), 0);
        chk("noreload_armed", 64'(armed), 0);
`endif

        // load failure with bit 7 stuck low
        go_idle();
        stuck_mask = 8'h80;
        pulse_start(8'hA5);
        tick(4); @(negedge clk);
        chk("lerr_set", 64'(load_err), 1);
        chk("lerr_armed", 64'(armed), 0);
        stuck_mask = '0;
        pulse_start(8'h3C);
        @(negedge clk);
        chk("lerr_cleared", 64'(load_err), 0);

        // stop while a record is pending
        tick(4);
        flip_mask = 8'h10;
        tick(2); @(negedge clk);
        chk("stoprep_valid", 64'(fault_valid), 1);
        chk("stoprep_q", 64'(fault_q), 64'h2C);
        stop = 1'b1; tick(1); stop = 1'b0;
        flip_mask = '0;
        tick(2); @(negedge clk);
        chk("stoprep_held", 64'(fault_valid), 1);
        fault_ready = 1'b1; tick(1); fault_ready = 1'b0;
        @(negedge clk);
        chk("stoprep_done", 64'(fault_valid), 0);
        chk("stoprep_en", 64'(dut_en), 0);
        tick(3); @(negedge clk);
        chk("stoprep_idle_armed", 64'(armed), 0);
        chk("stoprep_idle_en", 64'(dut_en), 0);

`ifdef FFMON_AUTO_RELOAD_EN
        // multi-shot with saturation
        go_idle();
        pulse_start(8'h5A);
        for (int k = 0; k < 5; k++) begin
            wait_armed(20);
            flip_mask = 8'(1 << $urandom_range(0, N - 1));
            tick(2); @(negedge clk);
            chk("shot_valid", 64'(fault_valid), 1);
            flip_mask = '0;
            fault_ready = 1'b1; tick(1); fault_ready = 1'b0;
            @(negedge clk);
            chk("shot_count", 64'(fault_count), 64'(exp_seq[k]));
            chk("shot_reload", 64'(dut_en), 1);
        end
`endif

        // random traffic with one asynchronous reset in the middle
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 15) == 0);
            stop        = ($urandom_range(0, 63) == 0);
            fault_ready = ($urandom_range(0, 3) == 0);
            pattern     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0)       flip_mask = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 9) == 0)   flip_mask = '0;
            if ($urandom_range(0, 199) == 0)      stuck_mask = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 49) == 0)  stuck_mask = '0;
            if (i == 1500) begin
                #3 reset_n = 1'b0;
                @(negedge clk);
                chk("async_rst_valid", 64'(fault_valid), 0);
                chk("async_rst_count", 64'(fault_count), 0);
                chk("async_rst_en", 64'(dut_en), 0);
                tick(2);
                reset_n = 1'b1;
            end
            tick(1);
        end
        start = 1'b0; stop = 1'b0; fault_ready = 1'b0;
        flip_mask = '0; stuck_mask = '0;
        tick(5);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
